// File: rtl/csr_unit.sv
// Machine-mode CSR file: mstatus/mtvec/mscratch/mepc/mcause, 64-bit cycle and
// retired-instruction counters, trap entry and MRET handling.
module csr_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [2:0]  csr_funct3,
    input  logic [11:0] csr_addr_EX,
    input  logic [31:0] csr_data_EX,
    input  logic        csr_src_zero,
    input  logic        instr_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret,
    output logic [31:0] csr_rdata,
    output logic        illegal_csr,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_o
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    // funct3[1:0] selects the operation; bit 2 only picks register vs immediate
    // operand, which is already muxed into csr_data_EX upstream.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    csr_op_e     op;
    logic        mapped;
    logic [31:0] old_value;
    logic        write_attempt;
    logic        do_write;
    logic        do_mret;
    logic [31:0] new_value;

    logic        wr_mstatus;
    logic        wr_mtvec;
    logic        wr_mscratch;
    logic        wr_mepc;
    logic        wr_mcause;
    logic        wr_mcycle_lo;
    logic        wr_mcycle_hi;
    logic        wr_minstret_lo;
    logic        wr_minstret_hi;

    assign op = csr_op_e'(csr_funct3[1:0]);

    // Read mux: current (pre-write) value of the addressed CSR.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and no latch is inferred.
        mapped    = 1'b1;
        old_value = 32'h0;
        case (csr_addr_EX)
            ADDR_MSTATUS:   old_value = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
            ADDR_MTVEC:     old_value = mtvec;
            ADDR_MSCRATCH:  old_value = mscratch;
            ADDR_MEPC:      old_value = mepc;
            ADDR_MCAUSE:    old_value = mcause;
            ADDR_MCYCLE,
            ADDR_CYCLE:     old_value = mcycle[31:0];
            ADDR_MCYCLEH,
            ADDR_CYCLEH:    old_value = mcycle[63:32];
            ADDR_MINSTRET,
            ADDR_INSTRET:   old_value = minstret[31:0];
            ADDR_MINSTRETH,
            ADDR_INSTRETH:  old_value = minstret[63:32];
            default:        mapped    = 1'b0;
        endcase
    end

    assign csr_rdata = old_value;

    // Set/clear forms with a zero source are pure reads and never fault on read-only space.
    assign write_attempt = (op == OP_RW) || !csr_src_zero;

    assign illegal_csr = csr_en &&
                         (!mapped ||
                          (op == OP_NONE) ||
                          ((csr_addr_EX[11:10] == 2'b11) && write_attempt));

    assign do_write = csr_en && !illegal_csr && write_attempt && !trap_valid;
    assign do_mret  = mret && !trap_valid;

    always_comb begin
        new_value = csr_data_EX;
        case (op)
            OP_RS:   new_value = old_value | csr_data_EX;
            OP_RC:   new_value = old_value & ~csr_data_EX;
            default: new_value = csr_data_EX;
        endcase
    end

    always_comb begin
        wr_mstatus     = do_write && (csr_addr_EX == ADDR_MSTATUS);
        wr_mtvec       = do_write && (csr_addr_EX == ADDR_MTVEC);
        wr_mscratch    = do_write && (csr_addr_EX == ADDR_MSCRATCH);
        wr_mepc        = do_write && (csr_addr_EX == ADDR_MEPC);
        wr_mcause      = do_write && (csr_addr_EX == ADDR_MCAUSE);
        wr_mcycle_lo   = do_write && (csr_addr_EX == ADDR_MCYCLE);
        wr_mcycle_hi   = do_write && (csr_addr_EX == ADDR_MCYCLEH);
        wr_minstret_lo = do_write && (csr_addr_EX == ADDR_MINSTRET);
        wr_minstret_hi = do_write && (csr_addr_EX == ADDR_MINSTRETH);
    end

    // Priority: rst > trap > mret > CSR write > counter increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values, matching the hardware.
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mtvec        <= 32'h0;
            mscratch     <= 32'h0;
            mepc         <= 32'h0;
            mcause       <= 32'h0;
            mcycle       <= 64'h0;
            minstret     <= 64'h0;
        end else begin
            if (trap_valid) begin
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (do_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (wr_mstatus) begin
                mstatus_mie  <= new_value[3];
                mstatus_mpie <= new_value[7];
            end

            if (trap_valid) begin
                mepc   <= trap_pc & 32'hFFFF_FFFC;
                mcause <= trap_cause;
            end else begin
                if (wr_mepc) begin
                    mepc <= new_value & 32'hFFFF_FFFC;
                end
                if (wr_mcause) begin
                    mcause <= new_value;
                end
            end

            if (wr_mtvec) begin
                mtvec <= new_value & 32'hFFFF_FFFC;
            end
            if (wr_mscratch) begin
                mscratch <= new_value;
            end

            // A write to either half replaces it and suppresses that counter's increment.
            if (wr_mcycle_lo) begin
                mcycle[31:0] <= new_value;
            end else if (wr_mcycle_hi) begin
                mcycle[63:32] <= new_value;
            end else begin
                mcycle <= mcycle + 64'd1;
            end

            if (wr_minstret_lo) begin
                minstret[31:0] <= new_value;
            end else if (wr_minstret_hi) begin
                minstret[63:32] <= new_value;
            end else if (instr_retire) begin
                minstret <= minstret + 64'd1;
            end
        end
    end

    assign mtvec_o = mtvec;
    assign mepc_o  = mepc;
    assign mie_o   = mstatus_mie;

endmodule
